// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LOAD  = 1'b1;

  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = imem_arb_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = imem_arb_pkg::DEF_DATA_W
);
  logic              f_req_i;
  logic [ADDR_W-1:0] f_addr_i;
  logic              f_gnt_o;
  logic              f_rvalid_o;
  logic [DATA_W-1:0] f_rdata_o;

  logic              l_req_i;
  logic              l_we_i;
  logic [ADDR_W-1:0] l_addr_i;
  logic [DATA_W-1:0] l_wdata_i;
  logic              l_gnt_o;
  logic              l_rvalid_o;
  logic [DATA_W-1:0] l_rdata_o;

  logic              lock_req_i;
  logic              lock_ack_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  f_req_i, f_addr_i, l_req_i, l_we_i, l_addr_i, l_wdata_i,
           lock_req_i, mem_rdata_i,
    output f_gnt_o, f_rvalid_o, f_rdata_o, l_gnt_o, l_rvalid_o, l_rdata_o,
           lock_ack_o, mem_addr_o, mem_we_o, mem_wdata_o
  );

  // Requester / memory side.
  modport master (
    output f_req_i, f_addr_i, l_req_i, l_we_i, l_addr_i, l_wdata_i,
           lock_req_i, mem_rdata_i,
    input  f_gnt_o, f_rvalid_o, f_rdata_o, l_gnt_o, l_rvalid_o, l_rdata_o,
           lock_ack_o, mem_addr_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/imem_arb_rr2.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module imem_arb_rr2
  import imem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[REQ_FETCH] && req[REQ_LOAD]) begin
      if (last == REQ_LOAD) gnt[REQ_FETCH] = 1'b1;
      else                  gnt[REQ_LOAD]  = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one instruction-memory port between fetch and loader, with a lock
// handshake for exclusive loader access. IMEM_ARB_PERF_EN adds perf counters.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  imem_arbiter_if.slave bus
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [15:0]  perf_fgnt_o,
  output logic [15:0]  perf_lgnt_o,
  output logic [15:0]  perf_fstall_o
`endif
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [1:0]        rr_req, rr_gnt;
  logic              f_gnt, l_gnt, lock_ack;
  logic              f_rvalid_q, l_rvalid_q;
  logic [DATA_W-1:0] f_rdata_q, l_rdata_q;
  logic [ADDR_W-1:0] mem_addr;

  imem_arb_rr2 u_rr2 (
    .req  (rr_req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    rr_req   = '0;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    lock_ack = 1'b0;
    unique case (state_q)
      RUN: begin
        rr_req[REQ_FETCH] = bus.f_req_i;
        rr_req[REQ_LOAD]  = bus.l_req_i;
        f_gnt = rr_gnt[REQ_FETCH];
        l_gnt = rr_gnt[REQ_LOAD];
        if (bus.lock_req_i) state_d = DRAIN;
      end
      DRAIN: state_d = LOCKED;
      LOCKED: begin
        l_gnt = bus.l_req_i;
        // Ack follows lock_req combinationally so it drops in the release cycle.
        if (bus.lock_req_i) lock_ack = 1'b1;
        else                state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
    if (f_gnt) last_d = REQ_FETCH;
    if (l_gnt) last_d = REQ_LOAD;
    if (state_q == LOCKED && !bus.lock_req_i) last_d = REQ_LOAD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      last_q  <= REQ_LOAD;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      f_rvalid_q <= f_gnt;
      l_rvalid_q <= l_gnt;
      if (f_gnt) f_rdata_q <= bus.mem_rdata_i;
      if (l_gnt) l_rdata_q <= bus.l_we_i ? '0 : bus.mem_rdata_i;
    end
  end

  assign mem_addr        = l_gnt ? bus.l_addr_i : bus.f_addr_i;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = l_gnt ? bus.l_wdata_i : '0;
  assign bus.mem_we_o    = l_gnt & bus.l_we_i;

  assign bus.f_gnt_o    = f_gnt;
  assign bus.l_gnt_o    = l_gnt;
  assign bus.lock_ack_o = lock_ack;
  assign bus.f_rvalid_o = f_rvalid_q;
  assign bus.f_rdata_o  = f_rdata_q;
  assign bus.l_rvalid_o = l_rvalid_q;
  assign bus.l_rdata_o  = l_rdata_q;

`ifdef IMEM_ARB_PERF_EN
  logic [15:0] fgnt_cnt, lgnt_cnt, fstall_cnt;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fgnt_cnt   <= '0;
      lgnt_cnt   <= '0;
      fstall_cnt <= '0;
    end else begin
      if (f_gnt && fgnt_cnt != '1) fgnt_cnt <= fgnt_cnt + 16'd1;
      if (l_gnt && lgnt_cnt != '1) lgnt_cnt <= lgnt_cnt + 16'd1;
      if (bus.f_req_i && !f_gnt && fstall_cnt != '1)
        fstall_cnt <= fstall_cnt + 16'd1;
    end
  end

  assign perf_fgnt_o   = fgnt_cnt;
  assign perf_lgnt_o   = lgnt_cnt;
  assign perf_fstall_o = fstall_cnt;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed scoreboard bench for imem_arbiter with a behavioural 64x32 memory.
module tb_imem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] mem_model [64];
  logic [31:0] ref_mem   [64];
  logic [31:0] fq[$];
  logic [31:0] lq[$];

  imem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

`ifdef IMEM_ARB_PERF_EN
  logic [15:0] perf_fgnt, perf_lgnt, perf_fstall;
`endif

  imem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
`ifdef IMEM_ARB_PERF_EN
    ,
    .perf_fgnt_o   (perf_fgnt),
    .perf_lgnt_o   (perf_lgnt),
    .perf_fstall_o (perf_fstall)
`endif
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata_i = mem_model[bus.mem_addr_o];
  always @(posedge clk) if (bus.mem_we_o) mem_model[bus.mem_addr_o] <= bus.mem_wdata_o;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_f_gnt"},    {31'd0, bus.f_gnt_o},    32'd0);
    check({tag, "_l_gnt"},    {31'd0, bus.l_gnt_o},    32'd0);
    check({tag, "_f_rvalid"}, {31'd0, bus.f_rvalid_o}, 32'd0);
    check({tag, "_l_rvalid"}, {31'd0, bus.l_rvalid_o}, 32'd0);
    check({tag, "_f_rdata"},  bus.f_rdata_o,           32'd0);
    check({tag, "_l_rdata"},  bus.l_rdata_o,           32'd0);
    check({tag, "_lock_ack"}, {31'd0, bus.lock_ack_o}, 32'd0);
    check({tag, "_mem_we"},   {31'd0, bus.mem_we_o},   32'd0);
  endtask

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic step(input logic fr, input logic [5:0] fa, input logic lr, input logic lw,
                      input logic [5:0] la, input logic [31:0] lwd, input logic lk,
                      input logic efg, input logic elg, input logic eack);
    logic [31:0] exp;
    bus.f_req_i = fr;  bus.f_addr_i = fa;
    bus.l_req_i = lr;  bus.l_we_i = lw;  bus.l_addr_i = la;  bus.l_wdata_i = lwd;
    bus.lock_req_i = lk;
    #1;
    check("f_gnt",    {31'd0, bus.f_gnt_o},    {31'd0, efg});
    check("l_gnt",    {31'd0, bus.l_gnt_o},    {31'd0, elg});
    check("lock_ack", {31'd0, bus.lock_ack_o}, {31'd0, eack});
    check("mem_we",   {31'd0, bus.mem_we_o},   {31'd0, elg & lw});
    if (efg) begin
      check("mem_addr_f", {26'd0, bus.mem_addr_o}, {26'd0, fa});
      fq.push_back(ref_mem[fa]);
    end
    if (elg) begin
      check("mem_addr_l", {26'd0, bus.mem_addr_o}, {26'd0, la});
      if (lw) check("mem_wdata", bus.mem_wdata_o, lwd);
      lq.push_back(lw ? 32'd0 : ref_mem[la]);
      if (lw) ref_mem[la] = lwd;
    end
    @(posedge clk); #1;
    check("f_rvalid", {31'd0, bus.f_rvalid_o}, {31'd0, efg});
    check("l_rvalid", {31'd0, bus.l_rvalid_o}, {31'd0, elg});
    if (efg) begin
      exp = (fq.size() != 0) ? fq.pop_front() : 32'hxxxx_xxxx;
      check("f_rdata", bus.f_rdata_o, exp);
    end
    if (elg) begin
      exp = (lq.size() != 0) ? lq.pop_front() : 32'hxxxx_xxxx;
      check("l_rdata", bus.l_rdata_o, exp);
    end
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.f_req_i = 1'b0; bus.l_req_i = 1'b0; bus.l_we_i = 1'b0; bus.lock_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_quiet("rst");
    fq.delete();
    lq.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int unsigned i = 0; i < 64; i++) begin
      mem_model[i] = 32'h1000_0000 | (i * 32'h0101);
      ref_mem[i]   = 32'h1000_0000 | (i * 32'h0101);
    end
    mem_model[0] = 32'h2008_0005;
    ref_mem[0]   = 32'h2008_0005;
    bus.f_addr_i = '0; bus.l_addr_i = '0; bus.l_wdata_i = '0;
    do_reset();
`ifdef IMEM_ARB_PERF_EN
    check("perf_rst", {16'd0, perf_fgnt}, 32'd0);
`endif

    // Fetch-only back-to-back reads.
    for (int unsigned a = 0; a < 3; a++)
      step(1'b1, 6'(a), 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // Continuous contention from reset alternates F,L,F,L.
    do_reset();
    for (int unsigned k = 0; k < 4; k++)
      step(1'b1, 6'd4, 1'b1, 1'b0, 6'd8, 32'd0, 1'b0, (k % 2) == 0, (k % 2) == 1, 1'b0);
    idle();

    // Loader write then fetch read of the top address.
    step(1'b0, 6'd0,  1'b1, 1'b1, 6'h3F, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 6'h3F, 1'b0, 1'b0, 6'h00, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    check("raw_data", bus.f_rdata_o, 32'hDEAD_BEEF);
    idle();

    // Lock: request cycle still arbitrated, one drain cycle, then loader only.
    step(1'b1, 6'd1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'd1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 10; k++) begin
      if ((k % 2) == 0)
        step(1'b1, 6'd1, 1'b1, 1'b1, 6'(16 + k), 32'hA000_0000 + k, 1'b1, 1'b0, 1'b1, 1'b1);
      else
        step(1'b1, 6'd1, 1'b1, 1'b0, 6'(15 + k), 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    step(1'b1, 6'd1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'd5, 1'b1, 1'b0, 6'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b1, 1'b0, 6'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Async reset while locked with a loader response on the outputs.
    step(1'b0, 6'd0, 1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b1, 1'b0, 6'h3F, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    bus.l_req_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async_rst");
    bus.lock_req_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // RUN after release; also the perf-counter pattern (3 F, 2 L, 2 stalls).
    step(1'b1, 6'd2, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'd3, 1'b1, 1'b0, 6'd7, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 6'd3, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'd6, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 6'd6, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
`ifdef IMEM_ARB_PERF_EN
    check("perf_fgnt",   {16'd0, perf_fgnt},   32'd3);
    check("perf_lgnt",   {16'd0, perf_lgnt},   32'd2);
    check("perf_fstall", {16'd0, perf_fstall}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
